// File: rtl/fp_res_buf_pkg.sv
// Shared FPU result-classification package.
// Holds the class codes reported for fp_mul results and the function that
// turns the five one-hot class flags into a code.
package fp_res_buf_pkg;

  typedef enum logic [2:0] {
    CLS_NORM  = 3'd0,
    CLS_DNORM = 3'd1,
    CLS_ZERO  = 3'd2,
    CLS_INF   = 3'd3,
    CLS_NAN   = 3'd4,
    CLS_BAD   = 3'd7
  } cls_e;

  localparam int NAN_CNT_W = 16;

  // Exactly one flag set selects its code; none or several is inconsistent.
  function automatic cls_e encode_cls(input logic nan, input logic inf,
                                      input logic zero, input logic dnorm,
                                      input logic norm);
    case ({nan, inf, zero, dnorm, norm})
      5'b10000: return CLS_NAN;
      5'b01000: return CLS_INF;
      5'b00100: return CLS_ZERO;
      5'b00010: return CLS_DNORM;
      5'b00001: return CLS_NORM;
      default:  return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/fp_res_buf_if.sv
// Handshake bundle between fp_mul (upstream), the result buffer and its
// consumer (downstream).
//   in_valid/in_ready/in_p + class flags : push side
//   out_valid/out_ready/out_p/out_cls    : pop side
// master = the environment around the buffer, slave = the buffer itself.
interface fp_res_buf_if #(
  parameter int N_EXP = 11,
  parameter int N_MAN = 52
);
  localparam int W = N_EXP + N_MAN + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_p;
  logic         in_nan;
  logic         in_inf;
  logic         in_zero;
  logic         in_dnorm;
  logic         in_norm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic [2:0]   out_cls;

  modport master (
    output in_valid, in_p, in_nan, in_inf, in_zero, in_dnorm, in_norm, out_ready,
    input  in_ready, out_valid, out_p, out_cls
  );

  modport slave (
    input  in_valid, in_p, in_nan, in_inf, in_zero, in_dnorm, in_norm, out_ready,
    output in_ready, out_valid, out_p, out_cls
  );
endinterface

// File: rtl/fp_fifo.sv
// Plain synchronous FIFO, no bypass.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_valid/wr_ready   : push handshake (wr_ready = not full)
//   wr_data             : entry to store
//   rd_valid/rd_ready   : pop handshake (rd_valid = not empty)
//   rd_data             : head entry
//   count               : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fp_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  // Ready depends on occupancy only, so a pop never frees a slot for a
  // push in the same cycle.
  assign wr_ready = (count != FULL_CNT);
  assign rd_valid = (count != '0);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count, so stale
  // contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_res_buf.sv
// Result buffer behind fp_mul: classifies each product as it is pushed,
// stores {class, product} in a FIFO and keeps sticky class flags plus a
// saturating NaN counter.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : push/pop handshake, product word and class flags
//   count           : buffer occupancy
//   flag_*          : sticky class flags, set by accepted pushes
//   flag_clr        : synchronous clear of the sticky flags and nan_cnt
//   nan_cnt         : saturating count of accepted NaN results
module fp_res_buf
  import fp_res_buf_pkg::*;
#(
  parameter int N_EXP = 11,
  parameter int N_MAN = 52,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_res_buf_if.slave            bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   flag_nan,
  output logic                   flag_inf,
  output logic                   flag_zero,
  output logic                   flag_dnorm,
  output logic                   flag_bad,
  input  logic                   flag_clr,
  output logic [NAN_CNT_W-1:0]   nan_cnt
);
  localparam int W = N_EXP + N_MAN + 1;

  cls_e         in_cls;
  logic         push;
  logic [W+2:0] head;

  assign in_cls = encode_cls(bus.in_nan, bus.in_inf, bus.in_zero,
                             bus.in_dnorm, bus.in_norm);
  assign push   = bus.in_valid && bus.in_ready;

  fp_fifo #(
    .WIDTH (W + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (bus.in_valid),
    .wr_ready (bus.in_ready),
    .wr_data  ({in_cls, bus.in_p}),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (head),
    .count    (count)
  );

  assign bus.out_p   = head[W-1:0];
  assign bus.out_cls = head[W+2:W];

  // NOTE: the clear is written first and the push update after it; with
  // non-blocking assignments the later one wins, so a push coinciding with
  // flag_clr still leaves its own flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_nan   <= 1'b0;
      flag_inf   <= 1'b0;
      flag_zero  <= 1'b0;
      flag_dnorm <= 1'b0;
      flag_bad   <= 1'b0;
      nan_cnt    <= '0;
    end else begin
      if (flag_clr) begin
        flag_nan   <= 1'b0;
        flag_inf   <= 1'b0;
        flag_zero  <= 1'b0;
        flag_dnorm <= 1'b0;
        flag_bad   <= 1'b0;
        nan_cnt    <= '0;
      end
      if (push) begin
        case (in_cls)
          CLS_NAN: begin
            flag_nan <= 1'b1;
            if (flag_clr)               nan_cnt <= NAN_CNT_W'(1);
            else if (nan_cnt != '1)     nan_cnt <= nan_cnt + 1'b1;
          end
          CLS_INF:   flag_inf   <= 1'b1;
          CLS_ZERO:  flag_zero  <= 1'b1;
          CLS_DNORM: flag_dnorm <= 1'b1;
          CLS_BAD:   flag_bad   <= 1'b1;
          CLS_NORM:  ;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: doc/fp_res_buf.md
FP_RES_BUF -- requirements
Module: fp_res_buf

Interface
- REQ-001: Parameter N_EXP, default 11, exponent field width.
- REQ-002: Parameter N_MAN, default 52, mantissa field width; W = N_EXP+N_MAN+1.
- REQ-003: Parameter DEPTH, default 4, buffer entries, power of two, 2..16.
- REQ-004: clk  in  1  single clock; all state updates on the rising edge.
- REQ-005: rst  in  1  reset, asynchronous, active-high.
- REQ-006: in_valid  in  1  upstream result valid; input comes from fp_mul.
- REQ-007: in_ready  out  1  buffer can accept an entry.
- REQ-008: in_p  in  W  product word.
- REQ-009: in_nan, in_inf, in_zero, in_dnorm, in_norm  in  1 each  class flags of in_p.
- REQ-010: out_valid  out  1  head entry available.
- REQ-011: out_ready  in  1  downstream accepts the head entry.
- REQ-012: out_p  out  W  head product word.
- REQ-013: out_cls  out  3  head class code: 0 norm, 1 dnorm, 2 zero, 3 inf, 4 nan, 7 bad.
- REQ-014: count  out  log2(DEPTH)+1  current occupancy.
- REQ-015: flag_nan, flag_inf, flag_zero, flag_dnorm, flag_bad  out  1 each  sticky class flags.
- REQ-016: flag_clr  in  1  synchronous clear of sticky flags and nan_cnt.
- REQ-017: nan_cnt  out  16  saturating count of accepted NaN results.

Function
- REQ-018: A push occurs when in_valid && in_ready; a pop occurs when out_valid && out_ready.
- REQ-019: in_ready shall be high exactly when count < DEPTH; in_ready is not a function of out_ready.
- REQ-020: When the buffer is full, a simultaneous pop shall not enable a push in the same cycle.
- REQ-021: out_valid shall be high exactly when count > 0; there is no bypass, so a push into an empty buffer raises out_valid on the next cycle (latency 1).
- REQ-022: Simultaneous push and pop when 0 < count < DEPTH shall leave count unchanged, and data order shall be preserved (FIFO).
- REQ-023: Read and write pointers shall wrap modulo DEPTH.
- REQ-024: out_p and out_cls shall hold the head entry stable while out_valid && !out_ready.
- REQ-025: The class code shall be computed at push time.
- REQ-026: If exactly one class flag is set, the class code shall be its code; if zero or several are set, the code shall be 7.
- REQ-027: On a push, the sticky flag matching the stored code shall be set; code 7 sets flag_bad; code 0 sets no flag.
- REQ-028: On a push with code 4, nan_cnt shall increment, saturating at 0xFFFF.
- REQ-029: flag_clr shall clear all sticky flags and nan_cnt.
- REQ-030: If flag_clr coincides with a push, the push's effect wins: the matching flag ends set, the others end clear, and nan_cnt ends at 1 for a NaN push.
- REQ-031: Input class flags shall be ignored when no push occurs.
- REQ-032: out_p and out_cls contents are don't-care when out_valid = 0.

Reset
- REQ-033: While rst is high, count, the pointers, out_valid, the flags and nan_cnt shall be 0, and in_ready shall be 1.
- REQ-034: Reset mid-operation shall discard all buffered entries; storage contents need not be cleared.
- REQ-035: The first push shall be accepted on the first rising clk edge after rst deasserts.

Structure
- REQ-036: The class-code constants (CLS_NORM..CLS_BAD) and the encoding function shall live in a shared FPU package reused by fp_mul consumers.
- REQ-037: The storage shall be one sub-module, fp_fifo, parameterised by width and DEPTH, with a W+3-bit entry.
- REQ-038: The flag and counter logic shall stay in fp_res_buf.

Verification
- REQ-039: Push p = 0x3FF0000000000000 with in_norm = 1 into an empty buffer -> out_valid is 1 the next cycle, out_cls = 0, no flag is set.
- REQ-040: Push 5 entries with out_ready = 0 and DEPTH = 4 -> the 5th is refused (in_ready = 0), count = 4; with out_ready = 1 and in_valid held, the 4 entries pop in order and the 5th is accepted one cycle after the first pop.
- REQ-041: Push p = 0x7FF8000000000000 with in_nan = 1 three times -> nan_cnt = 3 and flag_nan = 1; then flag_clr alone -> nan_cnt = 0 and flag_nan = 0.
- REQ-042: flag_clr in the same cycle as a NaN push -> next cycle nan_cnt = 1, flag_nan = 1, flag_inf = 0.
- REQ-043: Push with in_zero = 1 and in_norm = 1 -> out_cls = 7, flag_bad = 1; push with all flags 0 -> out_cls = 7.
- REQ-044: Assert rst mid-stream with count = 3 -> out_valid, count and nan_cnt are 0 immediately (asynchronously), before the next clk edge.
